// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - 3x4 keypad scanner, debouncer and 4-digit entry buffer
//
// Purpose: drives one keypad column at a time, assembles a three-column frame,
// debounces single-key presses and releases over DEB_N frames, and maintains a
// four-digit BCD entry buffer with clear ('*') and commit ('#').
//
// Ports:
//   fin        clock, all logic on its rising edge
//   rst        asynchronous active-low reset
//   touch_key  row returns [3]=1-2-3 [2]=4-5-6 [1]=7-8-9 [0]=*-0-#
//   scan_key   one-hot column drive 100=1-4-7-* 010=2-5-8-0 001=3-6-9-#
//   key_valid  one-cycle pulse per accepted key event
//   key_code   last accepted key: 0-9, 10='*', 11='#'
//   digits     four BCD digits, [3:0] newest
//   digit_cnt  digits entered, 0..4
//   enter      one-cycle commit pulse, one cycle after the '#' key_valid
//
// Optional feature: define KEY_REPEAT_EN to auto-repeat held digit keys.

module keypad_entry_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int DEB_N     = 3,
    parameter int REP_FIRST = 32,
    parameter int REP_RATE  = 8
) (
    input  logic        fin,
    input  logic        rst,
    input  logic [3:0]  touch_key,
    output logic [2:0]  scan_key,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  digit_cnt,
    output logic        enter
);

    localparam int DW = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_HELD,
        ST_RELEASE
    } state_t;

    logic [DW-1:0] div_cnt;
    logic          tick;
    logic [3:0]    a0;
    logic [3:0]    a1;
    logic [1:0]    frm_ph;
    logic          frame_done;
    logic [11:0]   keys;
    logic [3:0]    nkeys;
    logic [3:0]    fcode;
    logic          f_none;
    logic          f_single;
    state_t        state;
    logic [3:0]    cand;
    logic [3:0]    cnt;

`ifdef KEY_REPEAT_EN
    localparam int RW = $clog2(REP_FIRST + 1);
    logic [RW-1:0] rep_cnt;
`endif

    // keys bit index -> key code; [11:8]=col 100, [7:4]=col 010, [3:0]=col 001,
    // within a column the bit order follows touch_key
    function automatic logic [3:0] code_of(input logic [3:0] idx);
        case (idx)
            4'd11: code_of = 4'd1;
            4'd10: code_of = 4'd4;
            4'd9:  code_of = 4'd7;
            4'd8:  code_of = 4'd10;
            4'd7:  code_of = 4'd2;
            4'd6:  code_of = 4'd5;
            4'd5:  code_of = 4'd8;
            4'd4:  code_of = 4'd0;
            4'd3:  code_of = 4'd3;
            4'd2:  code_of = 4'd6;
            4'd1:  code_of = 4'd9;
            default: code_of = 4'd11;
        endcase
    endfunction

    assign tick = (div_cnt == DW'(SCAN_DIV - 1));

    // frm_ph tracks how many columns of the current frame are valid, so a frame
    // is only judged when it started at column 100 and saw all three columns
    always_ff @(posedge fin or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            scan_key <= 3'b100;
            a0       <= '0;
            a1       <= '0;
            frm_ph   <= '0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                case (scan_key)
                    3'b100: begin
                        a0       <= touch_key;
                        frm_ph   <= 2'd1;
                        scan_key <= 3'b010;
                    end
                    3'b010: begin
                        a1       <= touch_key;
                        frm_ph   <= (frm_ph == 2'd1) ? 2'd2 : 2'd0;
                        scan_key <= 3'b001;
                    end
                    default: begin
                        frm_ph   <= 2'd0;
                        scan_key <= 3'b100;
                    end
                endcase
            end
        end
    end

    // third column is taken live from touch_key on the completing tick
    assign frame_done = tick && (scan_key == 3'b001) && (frm_ph == 2'd2);
    assign keys       = {a0, a1, touch_key};

    always_comb begin
        nkeys = 4'd0;
        fcode = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (keys[i]) begin
                nkeys = nkeys + 4'd1;
                fcode = code_of(4'(i));
            end
        end
    end

    assign f_none   = (nkeys == 4'd0);
    assign f_single = (nkeys == 4'd1);

    always_ff @(posedge fin or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_valid <= 1'b0;
            key_code  <= '0;
`ifdef KEY_REPEAT_EN
            rep_cnt   <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (frame_done) begin
                case (state)
                    ST_IDLE: begin
                        if (f_single) begin
                            cand <= fcode;
                            cnt  <= 4'd1;
                            if (DEB_N == 1) begin
                                key_valid <= 1'b1;
                                key_code  <= fcode;
                                state     <= ST_HELD;
`ifdef KEY_REPEAT_EN
                                rep_cnt   <= RW'(DEB_N);
`endif
                            end else begin
                                state <= ST_DEBOUNCE;
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (f_single && fcode == cand) begin
                            if (cnt + 4'd1 == 4'(DEB_N)) begin
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                state     <= ST_HELD;
`ifdef KEY_REPEAT_EN
                                // repeat timing counts frames from the start of the press
                                rep_cnt   <= RW'(DEB_N);
`endif
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                    ST_HELD: begin
                        if (f_none) begin
                            cnt   <= 4'd1;
                            state <= (DEB_N == 1) ? ST_IDLE : ST_RELEASE;
`ifdef KEY_REPEAT_EN
                            rep_cnt <= '0;
`endif
                        end
`ifdef KEY_REPEAT_EN
                        else if (f_single && fcode == cand && cand <= 4'd9) begin
                            if (rep_cnt == RW'(REP_FIRST - 1)) begin
                                key_valid <= 1'b1;
                                key_code  <= cand;
                                rep_cnt   <= RW'(REP_FIRST - REP_RATE);
                            end else begin
                                rep_cnt <= rep_cnt + 1'b1;
                            end
                        end else begin
                            rep_cnt <= '0;
                        end
`endif
                    end
                    default: begin
                        if (f_none) begin
                            if (cnt + 4'd1 == 4'(DEB_N)) begin
                                state <= ST_IDLE;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state <= ST_HELD;
                        end
                    end
                endcase
            end
        end
    end

    // entry buffer acts on the registered key event, so '#' commits one cycle
    // after its key_valid and the buffer clears one cycle after that
    always_ff @(posedge fin or negedge rst) begin
        if (!rst) begin
            digits    <= '0;
            digit_cnt <= '0;
            enter     <= 1'b0;
        end else begin
            enter <= key_valid && (key_code == 4'd11);
            if (enter) begin
                digits    <= '0;
                digit_cnt <= '0;
            end else if (key_valid) begin
                if (key_code <= 4'd9) begin
                    if (digit_cnt != 3'd4) begin
                        digits    <= {digits[11:0], key_code};
                        digit_cnt <= digit_cnt + 3'd1;
                    end
                end else if (key_code == 4'd10) begin
                    digits    <= '0;
                    digit_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - scoreboard bench for keypad_entry_ctrl

module tb_keypad_entry_ctrl;

    localparam int FRAME = 12;   // SCAN_DIV=4 cycles x 3 columns

    logic        fin;
    logic        rst;
    logic [3:0]  touch_key;
    logic [2:0]  scan_key;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] digits;
    logic [2:0]  digit_cnt;
    logic        enter;

    logic [11:0] pressed;        // bit n set = key with code n held down

    logic [3:0]  exp_q[$];
    logic [18:0] enter_q[$];     // {digit_cnt, digits} expected at enter
    logic [3:0]  ee;
    logic [18:0] ent;
    logic        prev_hash;
    logic        chk_clear;
    int          ev_cnt;
    int          base;
    int          n_checks;
    int          n_err;

    keypad_entry_ctrl #(
        .SCAN_DIV  (4),
        .DEB_N     (3),
        .REP_FIRST (32),
        .REP_RATE  (8)
    ) dut (
        .fin       (fin),
        .rst       (rst),
        .touch_key (touch_key),
        .scan_key  (scan_key),
        .key_valid (key_valid),
        .key_code  (key_code),
        .digits    (digits),
        .digit_cnt (digit_cnt),
        .enter     (enter)
    );

    initial fin = 1'b0;
    always #5 fin = ~fin;

    // keypad matrix: rows of the driven column reflect held keys
    always_comb begin
        touch_key = 4'b0000;
        case (scan_key)
            3'b100:  touch_key = {pressed[1], pressed[4], pressed[7], pressed[10]};
            3'b010:  touch_key = {pressed[2], pressed[5], pressed[8], pressed[0]};
            3'b001:  touch_key = {pressed[3], pressed[6], pressed[9], pressed[11]};
            default: touch_key = 4'b0000;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: pops expected events whenever the DUT presents one
    always @(negedge fin) begin
        if (rst) begin
            if (chk_clear) begin
                check("post_enter_digits", 32'(digits), 32'h0);
                check("post_enter_cnt", 32'(digit_cnt), 32'h0);
                chk_clear = 1'b0;
            end
            if (key_valid) begin
                ev_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_key_valid", 32'(key_valid), 32'h0);
                end else begin
                    ee = exp_q.pop_front();
                    check("key_code", 32'(key_code), 32'(ee));
                end
            end
            if (enter) begin
                check("enter_follows_hash", 32'(prev_hash), 32'h1);
                if (enter_q.size() == 0) begin
                    check("unexpected_enter", 32'(enter), 32'h0);
                end else begin
                    ent = enter_q.pop_front();
                    check("enter_digits", 32'(digits), 32'(ent[15:0]));
                    check("enter_cnt", 32'(digit_cnt), 32'(ent[18:16]));
                end
                chk_clear = 1'b1;
            end
            prev_hash = key_valid && (key_code == 4'd11);
        end else begin
            prev_hash = 1'b0;
            chk_clear = 1'b0;
        end
    end

    task automatic frames(input int n);
        repeat (FRAME * n) @(negedge fin);
    endtask

    task automatic hold(input int code, input int nf);
        pressed = 12'(1) << code;
        frames(nf);
        pressed = '0;
        frames(4);
    endtask

    task automatic key(input int code);
        exp_q.push_back(4'(code));
        hold(code, 4);
    endtask

    initial begin
        n_checks  = 0;
        n_err     = 0;
        ev_cnt    = 0;
        prev_hash = 1'b0;
        chk_clear = 1'b0;
        pressed   = '0;
        rst       = 1'b0;
        repeat (3) @(negedge fin);
        #1;
        check("rst_scan_key", 32'(scan_key), 32'h4);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_digit_cnt", 32'(digit_cnt), 32'h0);
        check("rst_enter", 32'(enter), 32'h0);
        @(negedge fin);
        rst = 1'b1;

        // '5' held for 5 frames
        exp_q.push_back(4'd5);
        hold(5, 5);
        #1;
        check("d5_digits", 32'(digits), 32'h0005);
        check("d5_cnt", 32'(digit_cnt), 32'h1);
        check("d5_code_hold", 32'(key_code), 32'h5);
        key(10);
        #1;
        check("star_digits", 32'(digits), 32'h0);

        // bounce on '8': 2 frames, gap, 3 frames
        base = ev_cnt;
        pressed = 12'(1) << 8;
        frames(2);
        pressed = '0;
        frames(1);
        exp_q.push_back(4'd8);
        pressed = 12'(1) << 8;
        frames(2);
        #1;
        check("bounce_no_early", 32'(ev_cnt), 32'(base));
        frames(1);
        #1;
        check("bounce_one_event", 32'(ev_cnt), 32'(base + 1));
        pressed = '0;
        frames(4);
        #1;
        check("bounce_digits", 32'(digits), 32'h0008);
        key(10);

        // overflow then clear
        key(1); key(2); key(3); key(4); key(9);
        #1;
        check("ovf_digits", 32'(digits), 32'h1234);
        check("ovf_cnt", 32'(digit_cnt), 32'h4);
        key(10);
        #1;
        check("clr_digits", 32'(digits), 32'h0);
        check("clr_cnt", 32'(digit_cnt), 32'h0);

        // enter
        key(7); key(0);
        exp_q.push_back(4'd11);
        enter_q.push_back({3'd2, 16'h0070});
        hold(11, 4);
        #1;
        check("after_enter_digits", 32'(digits), 32'h0);

        // '#' with empty buffer still commits
        exp_q.push_back(4'd11);
        enter_q.push_back({3'd0, 16'h0000});
        hold(11, 4);

        // multi-key: '1' and '3' together
        base = ev_cnt;
        pressed = (12'(1) << 1) | (12'(1) << 3);
        frames(5);
        pressed = '0;
        frames(4);
        #1;
        check("multi_no_event", 32'(ev_cnt), 32'(base));

        // reset during debounce of '6'
        key(3);
        #1;
        check("pre_rst_digits", 32'(digits), 32'h0003);
        pressed = 12'(1) << 6;
        frames(2);
        #1;
        rst = 1'b0;
        #1;
        check("mid_rst_scan_key", 32'(scan_key), 32'h4);
        check("mid_rst_key_valid", 32'(key_valid), 32'h0);
        check("mid_rst_key_code", 32'(key_code), 32'h0);
        check("mid_rst_digits", 32'(digits), 32'h0);
        check("mid_rst_cnt", 32'(digit_cnt), 32'h0);
        check("mid_rst_enter", 32'(enter), 32'h0);
        pressed = '0;
        @(negedge fin);
        @(negedge fin);
        rst = 1'b1;

        // long hold of '2' for 48 frames
        base = ev_cnt;
`ifdef KEY_REPEAT_EN
        repeat (4) exp_q.push_back(4'd2);
        hold(2, 48);
        #1;
        check("repeat_events", 32'(ev_cnt), 32'(base + 4));
        check("repeat_digits", 32'(digits), 32'h2222);
`else
        exp_q.push_back(4'd2);
        hold(2, 48);
        #1;
        check("hold_events", 32'(ev_cnt), 32'(base + 1));
        check("hold_digits", 32'(digits), 32'h0002);
`endif

        frames(1);
        check("exp_q_drained", 32'(exp_q.size()), 32'h0);
        check("enter_q_drained", 32'(enter_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry_ctrl.md
KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: fin cycles per column step (minimum 2).
REQ-002 SHALL have parameter DEB_N, default 3: consecutive matching scan frames needed to accept a press or release (1..15).
REQ-003 SHALL have parameter REP_FIRST, default 32: held frames before the first auto-repeat.
REQ-004 SHALL have parameter REP_RATE, default 8: frames between later auto-repeats.
REQ-005 SHALL have port fin, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port touch_key, input, 4 bits: row returns, active-high; [3]=row 1-2-3, [2]=4-5-6, [1]=7-8-9, [0]=*-0-#.
REQ-008 SHALL have port scan_key, output, 3 bits: one-hot column drive; 100=col 1-4-7-*, 010=col 2-5-8-0, 001=col 3-6-9-#.
REQ-009 SHALL have port key_valid, output, 1 bit: one-cycle pulse per accepted key event.
REQ-010 SHALL have port key_code, output, 4 bits: code of the last accepted key; 0-9 digits, 10='*', 11='#'.
REQ-011 SHALL have port digits, output, 16 bits: four BCD digits; [3:0] is the newest digit.
REQ-012 SHALL have port digit_cnt, output, 3 bits: number of digits entered, 0..4.
REQ-013 SHALL have port enter, output, 1 bit: one-cycle pulse meaning the entry is committed.

Function
REQ-014 SHALL count fin cycles from 0 to SCAN_DIV-1; the cycle at SCAN_DIV-1 is a tick, and the count then wraps to 0.
REQ-015 SHALL, on each tick, sample touch_key for the active column and then rotate scan_key 100->010->001->100; any non-one-hot value SHALL recover to 100 on the next tick.
REQ-016 SHALL assemble one frame from three consecutive column samples, starting at column 100; frame result is NONE (no row set), SINGLE(code) (exactly one of 12 keys set) or MULTI (two or more keys set).
REQ-017 SHALL run an FSM with states IDLE, DEBOUNCE, HELD and RELEASE, evaluated once per completed frame.
REQ-018 SHALL, in IDLE, go to DEBOUNCE on SINGLE(c), with candidate=c and count=1; NONE or MULTI keeps IDLE.
REQ-019 SHALL, in DEBOUNCE, increment count on SINGLE(same c); any other frame result returns to IDLE.
REQ-020 SHALL, when the DEBOUNCE count reaches DEB_N, drive key_valid=1 for exactly one fin cycle, load key_code=c in that same cycle, and enter HELD.
REQ-021 SHALL, in HELD, move to RELEASE with count=1 on a NONE frame; SINGLE or MULTI keeps HELD.
REQ-022 SHALL, in RELEASE, return to IDLE after DEB_N consecutive NONE frames; any non-NONE frame returns to HELD with no new event.
REQ-023 SHALL, on a key_valid for digit d with digit_cnt<4, set digits={digits[11:0],d} and increment digit_cnt.
REQ-024 SHALL, on a key_valid for a digit with digit_cnt==4, leave digits and digit_cnt unchanged.
REQ-025 SHALL, on a key_valid for '*', clear digits to 0 and digit_cnt to 0.
REQ-026 SHALL, on a key_valid for '#', pulse enter one cycle later with digits and digit_cnt still unchanged, and clear both in the cycle after enter.
REQ-027 SHALL, on '#' with digit_cnt==0, still pulse enter.
REQ-028 SHALL keep key_code holding its value between events.

Reset
REQ-029 SHALL, while rst=0, force scan_key=100, divider=0, FSM=IDLE, partial frame discarded, key_valid=0, key_code=0, digits=0, digit_cnt=0, enter=0.
REQ-030 SHALL let a mid-press or pending enter be lost on reset; the first frame after release of reset starts at column 100.

Configuration
REQ-031 SHALL, with macro KEY_REPEAT_EN defined, while in HELD on a digit key, emit an extra key_valid with the same key_code after REP_FIRST held frames and then every REP_RATE frames.
REQ-032 SHALL never auto-repeat '*' or '#', and any non-SINGLE(same) frame SHALL restart the repeat count.
REQ-033 SHALL, with KEY_REPEAT_EN undefined, emit exactly one key_valid per press; REP_FIRST and REP_RATE are then ignored and no repeat counter is built.

Verification
REQ-034 SHALL cover a digit press: SCAN_DIV=4, DEB_N=3, hold '5' (touch_key=0100 while scan_key=010) for 5 frames then release -> exactly one key_valid, key_code=5, digits=0x0005, digit_cnt=1.
REQ-035 SHALL cover a bounce: '8' present for 2 frames, NONE, then 3 frames -> one key_valid only, after the third stable frame.
REQ-036 SHALL cover overflow and clear: keys 1,2,3,4,9 -> digits=0x1234, digit_cnt=4; then '*' -> digits=0, digit_cnt=0.
REQ-037 SHALL cover enter: keys 7,0 then '#' -> enter pulse one cycle after key_valid with digits=0x0070, and digits=0 the following cycle.
REQ-038 SHALL cover multi-key: '1' and '3' held together -> no key_valid, FSM stays IDLE.
REQ-039 SHALL cover reset mid-debounce: rst=0 during the DEBOUNCE of '6' -> all outputs at reset values, scan_key=100; with KEY_REPEAT_EN defined, holding '2' for 48 frames gives key_valid count 1+1+2=4.
